// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared state encoding and default sizing for the serial pattern detector.
package seq_det_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam int DEF_MAX_LEN = 8;
   localparam int DEF_CNT_W = 8;
endpackage

// File: rtl/seq_detect_ctrl_if.sv
// seq_detect_ctrl_if: configuration, control, stream and status bundle of the detector.
interface seq_detect_ctrl_if import seq_det_pkg::*; #(
   parameter int MAX_LEN = DEF_MAX_LEN,
   parameter int CNT_W = DEF_CNT_W
);
   localparam int LEN_W = $clog2(MAX_LEN) + 1;
   logic cfg_we;
   logic [MAX_LEN-1:0] cfg_pattern;
   logic [LEN_W-1:0] cfg_len;
   logic cfg_overlap;
   logic [CNT_W-1:0] cfg_target;
   logic start;
   logic abort;
   logic x_valid;
   logic x;
   logic z;
   logic [CNT_W-1:0] match_count;
   logic busy;
   logic done;
   logic cfg_err;
   modport master (
      output cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_target, start, abort, x_valid, x,
      input z, match_count, busy, done, cfg_err
   );
   modport slave (
      input cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_target, start, abort, x_valid, x,
      output z, match_count, busy, done, cfg_err
   );
endinterface

// File: rtl/seq_match_core.sv
// seq_match_core: shift history, count fresh bits and flag a masked pattern match on the
// incoming bit; hit is combinational and refers to the post-shift history.
module seq_match_core import seq_det_pkg::*; #(
   parameter int MAX_LEN = DEF_MAX_LEN,
   localparam int LEN_W = $clog2(MAX_LEN) + 1
) (
   input logic clk,
   input logic reset,
   input logic en,
   input logic clr,
   input logic x,
   input logic [MAX_LEN-1:0] pattern,
   input logic [LEN_W-1:0] len,
   input logic overlap,
   output logic hit
);
   logic [MAX_LEN-1:0] history, hist_n, mask;
   logic [LEN_W-1:0] seen, seen_n;
   always_comb begin
      hist_n = {history[MAX_LEN-2:0], x};
      seen_n = (seen >= len) ? len : seen + 1'b1;
      mask = ~({MAX_LEN{1'b1}} << len);
      hit = en && (seen_n >= len) && (((hist_n ^ pattern) & mask) == '0);
   end
   // non-overlap mode restarts the fresh-bit count so the next match needs len new bits
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         history <= '0;
         seen <= '0;
      end else if (clr) begin
         history <= '0;
         seen <= '0;
      end else if (en) begin
         history <= hist_n;
         seen <= (hit && !overlap) ? '0 : seen_n;
      end
   end
endmodule

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: programmable serial pattern detector with config registers, IDLE/RUN/DONE
// sequencing, saturating match counter and a registered one-cycle match pulse z.
module seq_detect_ctrl import seq_det_pkg::*; #(
   parameter int MAX_LEN = DEF_MAX_LEN,
   parameter int CNT_W = DEF_CNT_W
) (
   input logic clk,
   input logic reset,
   seq_detect_ctrl_if.slave bus
);
   localparam int LEN_W = $clog2(MAX_LEN) + 1;
   state_t state;
   logic [MAX_LEN-1:0] pattern;
   logic [LEN_W-1:0] len;
   logic overlap;
   logic [CNT_W-1:0] target, cnt, cnt_n;
   logic z, cfg_err, run, abt, cfg_ok, go, shift, hit;
   always_comb begin
      run = state == RUN;
      abt = bus.abort && state != IDLE;
      cfg_ok = bus.cfg_len != '0 && bus.cfg_len <= LEN_W'(MAX_LEN);
      go = bus.start && !run && !abt && len != '0;
      shift = run && bus.x_valid && !abt;
      cnt_n = &cnt ? cnt : cnt + 1'b1;
   end
   seq_match_core #(.MAX_LEN(MAX_LEN)) u_core (
      .clk(clk),
      .reset(reset),
      .en(shift),
      .clr(go),
      .x(bus.x),
      .pattern(pattern),
      .len(len),
      .overlap(overlap),
      .hit(hit)
   );
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         pattern <= '0;
         len <= '0;
         overlap <= 1'b0;
         target <= '0;
         cnt <= '0;
         z <= 1'b0;
         cfg_err <= 1'b0;
      end else begin
         if (!run && bus.cfg_we) begin
            if (cfg_ok) begin
               pattern <= bus.cfg_pattern;
               len <= bus.cfg_len;
               overlap <= bus.cfg_overlap;
               target <= bus.cfg_target;
               cfg_err <= 1'b0;
            end else cfg_err <= 1'b1;
         end
         // start checks the config registered before this edge, so a same-cycle write is not used
         if (abt) begin
            state <= IDLE;
            z <= 1'b0;
         end else if (bus.start && !run) begin
            z <= 1'b0;
            if (len != '0) begin
               state <= RUN;
               cnt <= '0;
            end else cfg_err <= 1'b1;
         end else if (run) begin
            z <= hit;
            if (hit) begin
               cnt <= cnt_n;
               if (target != '0 && cnt_n == target) state <= DONE;
            end
         end else z <= 1'b0;
      end
   end
   assign bus.z = z;
   assign bus.match_count = cnt;
   assign bus.busy = run;
   assign bus.done = state == DONE;
   assign bus.cfg_err = cfg_err;
endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb_seq_detect_ctrl: scoreboard bench; expected z/count/busy/done are queued as each bit is
// driven and compared one step after the sampling edge.
module tb_seq_detect_ctrl;
   import seq_det_pkg::*;
   typedef struct {
      string tag;
      logic z;
      logic [7:0] cnt;
      logic busy;
      logic done;
   } exp_t;
   exp_t sb[$];
   exp_t mon_e;
   int checks = 0;
   int errors = 0;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;
   seq_detect_ctrl_if #(.MAX_LEN(8), .CNT_W(8)) bus ();
   seq_detect_ctrl #(.MAX_LEN(8), .CNT_W(8)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask
   task automatic step(string tag, logic v, logic b, logic ez, int ecnt, logic ebusy, logic edone);
      exp_t e;
      @(negedge clk);
      bus.x_valid = v;
      bus.x = b;
      e.tag = tag;
      e.z = ez;
      e.cnt = 8'(ecnt);
      e.busy = ebusy;
      e.done = edone;
      sb.push_back(e);
      @(posedge clk);
   endtask
   task automatic cfg_write(logic [7:0] pat, logic [3:0] len, logic ov, logic [7:0] tgt);
      @(negedge clk);
      bus.x_valid = 1'b0;
      bus.cfg_we = 1'b1;
      bus.cfg_pattern = pat;
      bus.cfg_len = len;
      bus.cfg_overlap = ov;
      bus.cfg_target = tgt;
      @(negedge clk);
      bus.cfg_we = 1'b0;
   endtask
   task automatic pulse(logic s, logic a);
      @(negedge clk);
      bus.x_valid = 1'b0;
      bus.start = s;
      bus.abort = a;
      @(negedge clk);
      bus.start = 1'b0;
      bus.abort = 1'b0;
   endtask
   always @(posedge clk) begin
      #1;
      if (sb.size() != 0) begin
         mon_e = sb.pop_front();
         chk({mon_e.tag, "_z"}, bus.z, mon_e.z);
         chk({mon_e.tag, "_cnt"}, bus.match_count, mon_e.cnt);
         chk({mon_e.tag, "_busy"}, bus.busy, mon_e.busy);
         chk({mon_e.tag, "_done"}, bus.done, mon_e.done);
      end
   end
   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
   initial begin
      logic [6:0] s1, z1;
      logic [10:0] s2, z2;
      int c1[7] = '{0, 0, 0, 1, 1, 1, 2};
      int c2[11] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 2};
      s1 = 7'b1011011;
      z1 = 7'b0001001;
      s2 = 11'b10110111011;
      z2 = 11'b00010000001;
      {bus.cfg_we, bus.cfg_overlap, bus.start, bus.abort, bus.x_valid, bus.x} = '0;
      bus.cfg_pattern = '0;
      bus.cfg_len = '0;
      bus.cfg_target = '0;
      #3;
      chk("rst_z", bus.z, 0);
      chk("rst_cnt", bus.match_count, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_err", bus.cfg_err, 0);
      @(negedge clk);
      reset = 1'b0;
      // unconfigured start, bad write, then good write
      pulse(1, 0);
      chk("nocfg_busy", bus.busy, 0);
      chk("nocfg_err", bus.cfg_err, 1);
      cfg_write(8'b1011, 0, 1, 0);
      chk("len0_err", bus.cfg_err, 1);
      cfg_write(8'b1011, 4, 1, 0);
      chk("good_err", bus.cfg_err, 0);
      pulse(1, 0);
      chk("t1_busy", bus.busy, 1);
      for (int i = 0; i < 7; i++) step($sformatf("t1_b%0d", i + 1), 1, s1[6-i], z1[6-i], c1[i], 1, 0);
      step("t1_gap", 0, 0, 0, 2, 1, 0);
      pulse(0, 1);
      chk("t1_abort_busy", bus.busy, 0);
      chk("t1_abort_cnt", bus.match_count, 2);
      chk("t1_abort_z", bus.z, 0);
      // non-overlapping mode
      cfg_write(8'b1011, 4, 0, 0);
      pulse(1, 0);
      chk("t2_start_cnt", bus.match_count, 0);
      for (int i = 0; i < 11; i++) step($sformatf("t2_b%0d", i + 1), 1, s2[10-i], z2[10-i], c2[i], 1, 0);
      // target reached
      pulse(0, 1);
      cfg_write(8'b1011, 4, 1, 2);
      pulse(1, 0);
      for (int i = 0; i < 7; i++) step($sformatf("t3_b%0d", i + 1), 1, s1[6-i], z1[6-i], c1[i], i < 6, i == 6);
      for (int i = 0; i < 4; i++) step($sformatf("t3_post%0d", i), 1, s1[6-i], 0, 2, 0, 1);
      pulse(0, 1);
      chk("t3_abort_done", bus.done, 0);
      chk("t3_abort_cnt", bus.match_count, 2);
      // rejected write keeps the old config (1011, overlap, target 2)
      cfg_write(8'b0000, 0, 0, 0);
      chk("t4_bad_err", bus.cfg_err, 1);
      pulse(1, 0);
      chk("t4_busy", bus.busy, 1);
      chk("t4_cnt", bus.match_count, 0);
      for (int i = 0; i < 3; i++) begin
         step($sformatf("t4_b%0d", i + 1), 1, s1[6-i], 0, 0, 1, 0);
         for (int g = 0; g < 3; g++) step($sformatf("t4_g%0d_%0d", i + 1, g), 0, 1, 0, 0, 1, 0);
      end
      step("t4_b4", 1, 1, 1, 1, 1, 0);
      step("t4_after", 0, 0, 0, 1, 1, 0);
      cfg_write(8'b1011, 4, 1, 0);
      chk("t4_run_we_err", bus.cfg_err, 1);
      pulse(1, 1);
      chk("t4_abst_busy", bus.busy, 0);
      chk("t4_abst_done", bus.done, 0);
      chk("t4_abst_cnt", bus.match_count, 1);
      // async reset mid-run
      cfg_write(8'b1011, 4, 1, 0);
      chk("t5_err", bus.cfg_err, 0);
      pulse(1, 0);
      for (int i = 0; i < 7; i++) step($sformatf("t5_b%0d", i + 1), 1, s1[6-i], z1[6-i], c1[i], 1, 0);
      #3;
      reset = 1'b1;
      #1;
      chk("t5_rst_z", bus.z, 0);
      chk("t5_rst_cnt", bus.match_count, 0);
      chk("t5_rst_busy", bus.busy, 0);
      chk("t5_rst_done", bus.done, 0);
      chk("t5_rst_err", bus.cfg_err, 0);
      @(negedge clk);
      reset = 1'b0;
      pulse(1, 0);
      chk("t5_start_busy", bus.busy, 0);
      chk("t5_start_err", bus.cfg_err, 1);
      chk("sb_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
Programmable serial pattern-detection controller with a Moore-style registered match output. Software loads a pattern of 1..MAX_LEN bits, sets an overlap mode and a match target, then arms the block. It then scans a qualified serial bit stream, counts matches, and signals done once the target is reached. It generalises the fixed-pattern Moore detectors in the sequence-detector library into a configurable, sequenced resource.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (>=2)
CNT_W, 8, width of the match counter and target
LEN_W, $clog2(MAX_LEN)+1, width of the length field (derived; do not override)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
cfg_we  in  1  config write strobe
cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is received first, bit [0] last
cfg_len  in  LEN_W  pattern length, legal 1..MAX_LEN
cfg_overlap  in  1  1 = overlapping matches allowed
cfg_target  in  CNT_W  matches required before done; 0 = run forever
start  in  1  arm/restart pulse
abort  in  1  return to IDLE
x_valid  in  1  qualifies x
x  in  1  serial data bit
z  out  1  registered match pulse
match_count  out  CNT_W  matches since last start
busy  out  1  high in RUN
done  out  1  high in DONE
cfg_err  out  1  sticky error flag for illegal config or start

Behaviour:
- Reset (async, active-high): state=IDLE; config cleared to len=0 (unconfigured); history, bits_seen, z, match_count, busy, done, cfg_err all 0.
- FSM states: IDLE, RUN, DONE. busy=(state==RUN); done=(state==DONE); both decoded from the state register.
- cfg_we is accepted only in IDLE or DONE and ignored in RUN.
  - If cfg_len is 0 or >MAX_LEN: config is unchanged and cfg_err is set.
  - Otherwise: pattern/len/overlap/target are latched and cfg_err is cleared.
- start in IDLE or DONE:
  - With a valid config: go to RUN; clear match_count, history and bits_seen.
  - With len==0: stay in the current state and set cfg_err.
- abort in RUN or DONE goes to IDLE; match_count is held and z is cleared. abort together with start: abort wins. abort in IDLE has no effect.
- RUN, on each edge with x_valid=1:
  - history <= {history[MAX_LEN-2:0], x}.
  - bits_seen increments, saturating at len.
  - hit = (new bits_seen >= len) and (new history[len-1:0] == pattern[len-1:0]).
  - On hit: z<=1 for the next cycle only; match_count+1, saturating at all-ones.
  - On hit with overlap=0: bits_seen<=0, so the next match needs len fresh bits.
  - With overlap=1: history is retained.
- x_valid=0 in RUN: no state change; z<=0.
- x_valid is ignored outside RUN; z=0 outside RUN except as stated below.
- Latency: z is high exactly in the cycle after the edge that samples the final pattern bit. Back-to-back overlapping hits give consecutive z cycles.
- Target: when a hit makes match_count==cfg_target (target!=0), the next state is DONE. z is still high in the first DONE cycle. DONE holds until start, abort or reset.
- Target=0: the block stays in RUN indefinitely and match_count saturates.
- Reset mid-RUN returns immediately to the reset values; the config is lost.

Decomposition:
- seq_det_pkg: state enum (IDLE/RUN/DONE) and the MAX_LEN/CNT_W defaults.
- One sub-module, seq_match_core: history shift register, bits_seen counter, masked compare and overlap clear. Its inputs are shift enable, clear, pattern, len and overlap; its output is the hit flag.
- seq_detect_ctrl holds the config registers, FSM, counter and the z register.

Test Plan:
- Config pattern=1011, len=4, overlap=1, target=0; start; stream 1,0,1,1,0,1,1 with x_valid=1 -> z high in the cycles after bits 4 and 7; match_count=2.
- Same stream with overlap=0 -> match at bit 4 only; match_count=1. Then feed 1,0,1,1 -> match_count=2.
- target=2, overlap=1, same stream -> done=1 and busy=0 from the cycle after bit 7; z high in that same cycle; further bits are ignored and the count stays 2.
- cfg_len=0 write -> cfg_err=1 and config unchanged. start with no valid config -> state remains IDLE. A valid write then clears cfg_err.
- Stream 1,0,1 with x_valid gaps of 3 cycles between bits, then 1 -> exactly one match, with z one cycle after the final sample. Assert abort together with start during RUN -> IDLE, match_count held.
- Assert reset mid-RUN after 2 matches -> all outputs 0 immediately (asynchronous). A subsequent start -> cfg_err=1.
